// File: rtl/sensor_link_pkg.sv
// Shared definitions for the sensor telemetry link (transmitter and evaluator receiver).
package sensor_link_pkg;

  typedef enum logic [1:0] {IDLE, HDR, CH, CSUM} link_state_t;

  localparam logic [1:0] HDR_TAG = 2'b10;
  localparam int NUM_CH = 5;

  typedef logic [2:0] ch_idx_t;

  localparam ch_idx_t CH_ALT  = 3'd0;
  localparam ch_idx_t CH_TEMP = 3'd1;
  localparam ch_idx_t CH_RAD  = 3'd2;
  localparam ch_idx_t CH_OXY  = 3'd3;
  localparam ch_idx_t CH_LIFE = 3'd4;

endpackage

// File: rtl/sensor_stall_timer.sv
// Counts consecutive stalled cycles and flags a frame abort when TIMEOUT is reached.
module sensor_stall_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  output logic expire,
  output logic timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] stall_cnt_reg;
  logic          timeout_err_reg;

  // Expiry is flagged on the TIMEOUT-th stalled cycle so the abort lands on the next edge.
  assign expire      = stall && (stall_cnt_reg == LIMIT);
  assign timeout_err = timeout_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg   <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      timeout_err_reg <= expire;
      if (!stall || expire) stall_cnt_reg <= '0;
      else                  stall_cnt_reg <= stall_cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/sensor_frame_tx.sv
// Snapshots five sensor channels and sends them as a framed valid/ready word stream.
// Define FRAME_CHECKSUM_EN to append an XOR checksum word after the life channel.
module sensor_frame_tx
  import sensor_link_pkg::*;
#(
  parameter int DATA_W  = 10,
  parameter int SEQ_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_req,
  input  logic [DATA_W-1:0] altitude,
  input  logic [DATA_W-1:0] temp,
  input  logic [DATA_W-1:0] rad,
  input  logic [DATA_W-1:0] oxygen,
  input  logic [DATA_W-1:0] life,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [7:0]        drop_cnt,
  output logic              timeout_err
);

  link_state_t       state_reg, state_next;
  ch_idx_t           ch_idx_reg, ch_idx_next;
  logic [SEQ_W-1:0]  seq_reg, seq_latched_reg;
  logic [7:0]        drop_cnt_reg;
  logic [DATA_W-1:0] ch_in [NUM_CH];
  logic [DATA_W-1:0] snap [NUM_CH];
  logic [DATA_W-1:0] hdr_word;
  logic              start, hs, stall, expire;

  assign ch_in[CH_ALT]  = altitude;
  assign ch_in[CH_TEMP] = temp;
  assign ch_in[CH_RAD]  = rad;
  assign ch_in[CH_OXY]  = oxygen;
  assign ch_in[CH_LIFE] = life;

  assign out_valid = (state_reg != IDLE);
  assign busy      = out_valid;
  assign drop_cnt  = drop_cnt_reg;
  assign start     = (state_reg == IDLE) && sample_req;
  assign hs        = out_valid && out_ready;
  assign stall     = out_valid && !out_ready;

  // Snapshots load only when a frame starts, so mid-frame input changes never leak in.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_snap
    logic [DATA_W-1:0] value_reg;
    always_ff @(posedge clk) begin
      if (rst)        value_reg <= '0;
      else if (start) value_reg <= ch_in[gi];
    end
    assign snap[gi] = value_reg;
  end

  always_comb begin
    hdr_word = '0;
    hdr_word[DATA_W-1 -: 2] = HDR_TAG;
    hdr_word[SEQ_W-1:0]     = seq_latched_reg;
  end

`ifdef FRAME_CHECKSUM_EN
  logic [DATA_W-1:0] csum_word;
  always_comb begin
    csum_word = hdr_word;
    for (int i = 0; i < NUM_CH; i++) csum_word = csum_word ^ snap[i];
  end
`endif

  always_comb begin
    state_next  = state_reg;
    ch_idx_next = ch_idx_reg;
    out_data    = '0;
    out_last    = 1'b0;
    case (state_reg)
      IDLE: if (sample_req) state_next = HDR;
      HDR: begin
        out_data = hdr_word;
        if (hs) begin
          state_next  = CH;
          ch_idx_next = CH_ALT;
        end
      end
      CH: begin
        out_data = snap[ch_idx_reg];
`ifdef FRAME_CHECKSUM_EN
        if (hs && ch_idx_reg == CH_LIFE) state_next = CSUM;
`else
        out_last = (ch_idx_reg == CH_LIFE);
        if (hs && ch_idx_reg == CH_LIFE) state_next = IDLE;
`endif
        else if (hs) ch_idx_next = ch_idx_reg + 3'd1;
      end
      CSUM: begin
`ifdef FRAME_CHECKSUM_EN
        out_data = csum_word;
        out_last = 1'b1;
        if (hs) state_next = IDLE;
`else
        state_next = IDLE;
`endif
      end
      default: state_next = IDLE;
    endcase
    if (expire) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      ch_idx_reg      <= CH_ALT;
      seq_reg         <= '0;
      seq_latched_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      ch_idx_reg <= ch_idx_next;
      if (start) begin
        seq_latched_reg <= seq_reg;
        seq_reg         <= seq_reg + SEQ_W'(1);
      end
      if (sample_req && busy && drop_cnt_reg != 8'hFF)
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  sensor_stall_timer #(.TIMEOUT(TIMEOUT)) u_stall_timer (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .expire      (expire),
    .timeout_err (timeout_err)
  );

endmodule

// File: tb/tb_sensor_frame_tx.sv
// Self-checking bench for sensor_frame_tx: frame-level queue model plus directed literal checks.
module tb_sensor_frame_tx;

  localparam int DATA_W  = 10;
  localparam int SEQ_W   = 8;
  localparam int TIMEOUT = 4;
`ifdef FRAME_CHECKSUM_EN
  localparam int FL = 7;
`else
  localparam int FL = 6;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sample_req = 1'b0;
  logic [DATA_W-1:0] altitude = '0, temp = '0, rad = '0, oxygen = '0, life = '0;
  logic              out_valid, out_ready = 1'b0, out_last, busy, timeout_err;
  logic [DATA_W-1:0] out_data;
  logic [7:0]        drop_cnt;

  sensor_frame_tx #(.DATA_W(DATA_W), .SEQ_W(SEQ_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .sample_req(sample_req),
    .altitude(altitude), .temp(temp), .rad(rad), .oxygen(oxygen), .life(life),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .drop_cnt(drop_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DATA_W-1:0] data; logic last; } word_t;

  int checks = 0;
  int errors = 0;
  word_t             model_q [$];
  logic [DATA_W-1:0] seen [$];
  int                seq_m = 0, drop_m = 0, stall_m = 0, terr_count = 0;
  logic              terr_pending = 1'b0;
  logic              rst_q = 1'b0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  // Expected frame built from the rules: header, five channels in order, optional XOR word.
  function automatic void push_frame();
    logic [DATA_W-1:0] w [FL];
    logic [DATA_W-1:0] x;
    w[0] = 10'h200 | DATA_W'(seq_m % 256);
    w[1] = altitude; w[2] = temp; w[3] = rad; w[4] = oxygen; w[5] = life;
    x = '0;
    for (int i = 0; i < 6; i++) x = x ^ w[i];
    if (FL == 7) w[FL-1] = x;
    for (int i = 0; i < FL; i++) model_q.push_back('{w[i], (i == FL-1)});
    seq_m = (seq_m + 1) % 256;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (rst_q) begin
        chk("rst_valid", out_valid, 0); chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);   chk("rst_busy", busy, 0);
        chk("rst_drop", drop_cnt, 0);   chk("rst_terr", timeout_err, 0);
      end
      model_q.delete(); seq_m = 0; drop_m = 0; stall_m = 0; terr_pending = 1'b0;
    end else begin
      chk("valid", out_valid, model_q.size() != 0);
      chk("busy", busy, model_q.size() != 0);
      chk("drop_cnt", drop_cnt, drop_m);
      chk("timeout_err", timeout_err, terr_pending);
      if (model_q.size() != 0) begin
        chk("data", out_data, model_q[0].data);
        chk("last", out_last, model_q[0].last);
      end
      if (timeout_err) terr_count++;
      if (out_valid && out_ready) begin
        seen.push_back(out_data);
        if (out_last) $display("frame done last_word=%h drop_cnt=%0d", out_data, drop_cnt);
      end
      terr_pending = 1'b0;
      if (model_q.size() != 0) begin
        if (sample_req) drop_m = (drop_m < 255) ? drop_m + 1 : 255;
        if (out_ready) begin
          void'(model_q.pop_front());
          stall_m = 0;
        end else begin
          stall_m++;
          if (stall_m == TIMEOUT) begin
            model_q.delete(); stall_m = 0; terr_pending = 1'b1;
          end
        end
      end else if (sample_req) begin
        push_frame();
      end
    end
    rst_q = rst;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic send_req(input logic [9:0] a, t, r, o, l);
    altitude = a; temp = t; rad = r; oxygen = o; life = l;
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle got=busy exp=idle within %0d cycles", budget);
    end
  endtask

  logic [DATA_W-1:0] exp1 [7];

  task automatic check_frame1(string name);
    chk({name, "_len"}, seen.size(), FL);
    for (int i = 0; i < FL; i++)
      if (i < seen.size()) chk($sformatf("%s_w%0d", name, i), seen[i], exp1[i]);
  endtask

  initial begin
    exp1 = '{10'h200, 10'h300, 10'h001, 10'h000, 10'h001, 10'h001, 10'h101};
    tick();
    do_reset();

    // 1: back-to-back frame
    seen.delete(); out_ready = 1'b1;
    send_req(10'h300, 1, 0, 1, 1);
    wait_idle(20);
    check_frame1("t1");

    // 2: ready toggling every cycle
    do_reset(); seen.delete(); out_ready = 1'b0;
    send_req(10'h300, 1, 0, 1, 1);
    for (int i = 0; i < 40; i++) begin
      out_ready = ~out_ready;
      tick();
      if (!busy) break;
    end
    wait_idle(20);
    check_frame1("t2");

    // 3: inputs change right after the snapshot
    do_reset(); seen.delete(); out_ready = 1'b1;
    send_req(10'h300, 1, 0, 1, 1);
    altitude = 10'h3FF; temp = 10'h3FF; rad = 10'h3FF; oxygen = 10'h3FF; life = 10'h3FF;
    wait_idle(20);
    check_frame1("t3");

    // 4: requests while busy are dropped
    do_reset(); out_ready = 1'b1;
    send_req(10'h300, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      sample_req = 1'b1; tick(); sample_req = 1'b0; tick();
    end
    wait_idle(20);
    chk("t4_drop", drop_cnt, 3);
    seen.delete();
    send_req(10'h011, 2, 3, 4, 5);
    wait_idle(20);
    if (seen.size() > 0) chk("t4_hdr", seen[0], 10'h201);
    else chk("t4_len", seen.size(), FL);

    // 5: stall timeout
    do_reset(); out_ready = 1'b0; terr_count = 0;
    send_req(10'h300, 1, 0, 1, 1);
    wait_idle(20);
    tick(); tick();
    chk("t5_terr_pulses", terr_count, 1);
    chk("t5_busy", busy, 0);
    out_ready = 1'b1; seen.delete();
    send_req(10'h300, 1, 0, 1, 1);
    wait_idle(20);
    if (seen.size() > 0) chk("t5_hdr", seen[0], 10'h201);
    else chk("t5_len", seen.size(), FL);

    // 6: sequence wrap, then drop counter saturation
    do_reset(); out_ready = 1'b1; seen.delete();
    for (int k = 0; k < 257; k++) begin
      send_req(10'(k), 10'(k + 1), 10'(3 * k), 10'(~k), 10'(k ^ 10'h155));
      wait_idle(20);
    end
    chk("t6_len", seen.size(), 257 * FL);
    if (seen.size() == 257 * FL) begin
      chk("t6_hdr_ff", seen[255 * FL], 10'h2FF);
      chk("t6_hdr_wrap", seen[256 * FL], 10'h200);
    end
    sample_req = 1'b1;
    for (int i = 0; i < 350; i++) tick();
    sample_req = 1'b0;
    wait_idle(20);
    chk("t6_drop_sat", drop_cnt, 255);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
